// File: rtl/crc32_slice4_engine.sv
// Slice-by-4 reflected CRC-32 engine: one 32-bit word per cycle through four external lookup tables,
// with partial final words finished a byte at a time through table 0.
module crc32_slice4_engine #(
    parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [1:0]  in_bytes,
    output logic [31:0] t0_addr,
    output logic [31:0] t1_addr,
    output logic [31:0] t2_addr,
    output logic [31:0] t3_addr,
    input  logic [31:0] t0_rdata,
    input  logic [31:0] t1_rdata,
    input  logic [31:0] t2_rdata,
    input  logic [31:0] t3_rdata,
    output logic        crc_valid,
    input  logic        crc_ready,
    output logic [31:0] crc_out
);

    typedef enum logic [1:0] {RUN, TAIL, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] stage_data_q, stage_data_d;
    logic        stage_last_q, stage_last_d;
    logic [1:0]  stage_bytes_q, stage_bytes_d;
    logic        stage_valid_q, stage_valid_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        accept;
    logic [31:0] x;
    logic [31:0] tail_shift;
    logic [7:0]  tail_byte;

    // The stage is held back while a last word waits to be folded, so a message end costs one accept slot.
    assign in_ready   = (state_q == RUN) && !(stage_valid_q && stage_last_q);
    assign accept     = in_valid && in_ready;
    assign crc_valid  = (state_q == DONE);
    assign crc_out    = crc_q ^ CRC_XOROUT;
    assign x          = crc_q ^ stage_data_q;
    assign tail_shift = stage_data_q >> {cnt_q, 3'b000};
    assign tail_byte  = tail_shift[7:0];

    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        stage_data_d  = stage_data_q;
        stage_last_d  = stage_last_q;
        stage_bytes_d = stage_bytes_q;
        stage_valid_d = stage_valid_q;
        cnt_d         = cnt_q;
        t0_addr       = 32'h0;
        t1_addr       = 32'h0;
        t2_addr       = 32'h0;
        t3_addr       = 32'h0;

        if (accept) begin
            stage_data_d  = in_data;
            stage_last_d  = in_last;
            stage_bytes_d = in_bytes;
            stage_valid_d = 1'b1;
        end

        case (state_q)
            RUN: begin
                if (stage_valid_q) begin
                    if (!stage_last_q || stage_bytes_q == 2'd0) begin
                        t3_addr = {24'h0, x[7:0]};
                        t2_addr = {24'h0, x[15:8]};
                        t1_addr = {24'h0, x[23:16]};
                        t0_addr = {24'h0, x[31:24]};
                        crc_d   = t3_rdata ^ t2_rdata ^ t1_rdata ^ t0_rdata;
                        if (stage_last_q) begin
                            state_d = DONE;
                        end else if (!accept) begin
                            stage_valid_d = 1'b0;
                        end
                    end else begin
                        state_d = TAIL;
                        cnt_d   = 2'd0;
                    end
                end
            end
            TAIL: begin
                t0_addr = {24'h0, crc_q[7:0] ^ tail_byte};
                crc_d   = {8'h00, crc_q[31:8]} ^ t0_rdata;
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q + 2'd1 == stage_bytes_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (crc_ready) begin
                    crc_d         = CRC_INIT;
                    stage_valid_d = 1'b0;
                    state_d       = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            crc_q         <= CRC_INIT;
            stage_data_q  <= 32'h0;
            stage_last_q  <= 1'b0;
            stage_bytes_q <= 2'd0;
            stage_valid_q <= 1'b0;
            cnt_q         <= 2'd0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            stage_data_q  <= stage_data_d;
            stage_last_q  <= stage_last_d;
            stage_bytes_q <= stage_bytes_d;
            stage_valid_q <= stage_valid_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_crc32_slice4_engine.sv
// Self-checking bench for crc32_slice4_engine: models the four lookup tables and checks results
// against a bitwise CRC-32 reference computed directly from the message bytes.
module tb_crc32_slice4_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [1:0]  in_bytes;
    logic [31:0] t0_addr, t1_addr, t2_addr, t3_addr;
    logic [31:0] t0_rdata, t1_rdata, t2_rdata, t3_rdata;
    logic        crc_valid;
    logic        crc_ready;
    logic [31:0] crc_out;

    logic        readyMan;
    logic        readyRand;
    logic        randReady;
    logic [31:0] tab [4][256];
    logic [31:0] gotQ [$];
    int          errors = 0;
    int          checks = 0;
    int          addrErrs = 0;

    typedef struct {
        string       name;
        logic [31:0] w [3];
        int          nWords;
        logic [1:0]  lastBytes;
        logic [31:0] expCrc;
    } vec_t;

    crc32_slice4_engine dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_bytes(in_bytes),
        .t0_addr(t0_addr), .t1_addr(t1_addr), .t2_addr(t2_addr), .t3_addr(t3_addr),
        .t0_rdata(t0_rdata), .t1_rdata(t1_rdata), .t2_rdata(t2_rdata), .t3_rdata(t3_rdata),
        .crc_valid(crc_valid), .crc_ready(crc_ready), .crc_out(crc_out)
    );

    always #5 clk = ~clk;

    assign t0_rdata  = tab[0][t0_addr[7:0]];
    assign t1_rdata  = tab[1][t1_addr[7:0]];
    assign t2_rdata  = tab[2][t2_addr[7:0]];
    assign t3_rdata  = tab[3][t3_addr[7:0]];
    assign crc_ready = randReady ? readyRand : readyMan;

    // Results are collected mid-cycle, where a handshake is already decided for the next edge.
    always @(negedge clk) begin
        if (!rst && crc_valid && crc_ready) gotQ.push_back(crc_out);
        if (t0_addr[31:8] != 0 || t1_addr[31:8] != 0 || t2_addr[31:8] != 0 || t3_addr[31:8] != 0)
            addrErrs++;
    end

    initial begin
        readyRand = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            readyRand = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [31:0] refCrc(input logic [7:0] msg [$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (msg[i]) begin
            c = c ^ {24'h0, msg[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c ^ 32'hFFFFFFFF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one message word by word; lat returns edges from last accept until crc_valid is seen.
    task automatic applyStimulus(input logic [7:0] msg [$], input int gapPct, input bit measure,
                                 output int lat);
        int          nw;
        int          nb;
        int          guard;
        bit          acc;
        logic [31:0] word;
        nw  = (msg.size() + 3) / 4;
        lat = 0;
        @(posedge clk);
        #1;
        for (int w = 0; w < nw; w++) begin
            while ($urandom_range(0, 99) < gapPct) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                @(posedge clk);
                #1;
            end
            word = $urandom;
            nb   = 0;
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k < msg.size()) begin
                    word[8*k +: 8] = msg[4*w+k];
                    nb++;
                end
            end
            in_valid = 1'b1;
            in_data  = word;
            in_last  = (w == nw - 1);
            in_bytes = (w == nw - 1) ? 2'(nb) : 2'($urandom_range(0, 3));
            acc      = 1'b0;
            guard    = 0;
            while (!acc) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                guard++;
                if (!acc && guard > 50) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL accept_timeout: got no in_ready expected in_ready within 50 cycles");
                    acc = 1'b1;
                end
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        if (measure) begin
            for (int i = 0; i < 20; i++) begin
                if (crc_valid) break;
                @(posedge clk);
                #1;
                lat++;
            end
        end
    endtask

    task automatic waitCrc(input string name, input logic [31:0] exp);
        int guard;
        guard = 0;
        while (gotQ.size() == 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (gotQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no crc_valid expected 0x%08h", name, exp);
        end else begin
            checkOutput(name, gotQ.pop_front(), exp);
        end
    endtask

    function automatic void vecToBytes(input vec_t v, output logic [7:0] msg [$]);
        int nb;
        msg = {};
        for (int w = 0; w < v.nWords; w++) begin
            nb = (w < v.nWords - 1 || v.lastBytes == 0) ? 4 : int'(v.lastBytes);
            for (int k = 0; k < nb; k++) msg.push_back(v.w[w][8*k +: 8]);
        end
    endfunction

    initial begin
        vec_t        vecs [3];
        logic [7:0]  msg [$];
        logic [7:0]  msgA [$];
        logic [7:0]  msg9 [$];
        logic [31:0] c;
        logic [31:0] held;
        int          lat;
        int          len;

        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            tab[0][i] = c;
        end
        for (int k = 1; k < 4; k++)
            for (int i = 0; i < 256; i++)
                tab[k][i] = (tab[k-1][i] >> 8) ^ tab[0][tab[k-1][i][7:0]];

        vecs[0] = '{name: "vec_123456789", w: '{32'h34333231, 32'h38373635, 32'h00000039},
                    nWords: 3, lastBytes: 2'd1, expCrc: 32'hCBF43926};
        vecs[1] = '{name: "vec_a", w: '{32'h00000061, 32'h0, 32'h0},
                    nWords: 1, lastBytes: 2'd1, expCrc: 32'hE8B7BE43};
        vecs[2] = '{name: "vec_abc", w: '{32'h00636261, 32'h0, 32'h0},
                    nWords: 1, lastBytes: 2'd3, expCrc: 32'h352441C2};
        vecToBytes(vecs[0], msg9);
        vecToBytes(vecs[1], msgA);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        in_bytes  = 2'd0;
        readyMan  = 1'b1;
        randReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_crc_valid", 32'(crc_valid), 32'd0);
        checkOutput("reset_crc_out", crc_out, 32'h0);
        checkOutput("reset_t0_addr", t0_addr, 32'h0);
        checkOutput("reset_t3_addr", t3_addr, 32'h0);

        $display("[TB] table vectors");
        for (int v = 0; v < 3; v++) begin
            vecToBytes(vecs[v], msg);
            applyStimulus(msg, 0, 1'b1, lat);
            checkOutput({vecs[v].name, "_latency"}, 32'(lat), 32'(vecs[v].lastBytes) + 32'd1);
            waitCrc(vecs[v].name, vecs[v].expCrc);
        end

        $display("[TB] stalled result handshake");
        readyMan = 1'b0;
        applyStimulus(msgA, 0, 1'b1, lat);
        held = crc_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_crc_valid", 32'(crc_valid), 32'd1);
            checkOutput("stall_crc_out", crc_out, held);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        readyMan = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("after_hs_in_ready", 32'(in_ready), 32'd1);
        checkOutput("after_hs_crc_valid", 32'(crc_valid), 32'd0);
        waitCrc("stall_result", 32'hE8B7BE43);

        $display("[TB] back to back messages");
        applyStimulus(msg9, 0, 1'b0, lat);
        applyStimulus(msgA, 0, 1'b0, lat);
        waitCrc("b2b_first", 32'hCBF43926);
        waitCrc("b2b_second", 32'hE8B7BE43);

        $display("[TB] input gaps");
        applyStimulus(msg9, 50, 1'b0, lat);
        waitCrc("gaps_123456789", 32'hCBF43926);

        $display("[TB] reset during tail");
        applyStimulus(msg9, 0, 1'b0, lat);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_crc_valid", 32'(crc_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_crc_out", crc_out, 32'h0);
        checkOutput("midrst_t0_addr", t0_addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("midrst_no_result", 32'(gotQ.size()), 32'd0);
        applyStimulus(msg9, 0, 1'b0, lat);
        waitCrc("rerun_123456789", 32'hCBF43926);

        $display("[TB] random messages");
        randReady = 1'b1;
        for (int m = 0; m < 30; m++) begin
            len = $urandom_range(1, 23);
            msg = {};
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            applyStimulus(msg, 50, 1'b0, lat);
            waitCrc("random_msg", refCrc(msg));
        end
        randReady = 1'b0;

        checkOutput("addr_upper_zero", 32'(addrErrs), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
